booth_seq_ctrl: RTL

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

---
 rtl/booth_seq_ctrl_pkg.sv | 22 ++
 rtl/booth_seq_ctrl_if.sv | 41 ++++
 rtl/op_fifo2.sv | 67 ++++++
 rtl/booth_seq_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/booth_seq_ctrl_pkg.sv
// Shared constants and types for the Booth multiplier sequencer.
// Operand width, step count, FSM encoding and operand-pair bundle.
package booth_seq_ctrl_pkg;

  localparam int N_BITS      = 8;
  localparam int P_BITS      = 2 * N_BITS;
  localparam int BOOTH_STEPS = 8;

  localparam logic [N_BITS-1:0] MIN_OPERAND = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } state_e;

  typedef struct packed {
    logic [N_BITS-1:0] a;
    logic [N_BITS-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand, result and multiplier-datapath signals of the sequencer.
// slave = sequencer side, master = environment side.
interface booth_seq_ctrl_if;
  import booth_seq_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_a;
  logic [N_BITS-1:0] in_b;

  logic              out_valid;
  logic              out_ready;
  logic [P_BITS-1:0] out_p;
  logic              out_ovf;

  logic              mul_load;
  logic [N_BITS-1:0] mul_a;
  logic [N_BITS-1:0] mul_b;
  logic [P_BITS-1:0] mul_p;

  logic              busy;

  modport slave (
    input  in_valid, in_a, in_b,
    input  out_ready, mul_p,
    output in_ready, out_valid,
    output out_p, out_ovf,
    output mul_load, mul_a, mul_b,
    output busy
  );

  modport master (
    output in_valid, in_a, in_b,
    output out_ready, mul_p,
    input  in_ready, out_valid,
    input  out_p, out_ovf,
    input  mul_load, mul_a, mul_b,
    input  busy
  );

endinterface

// File: rtl/op_fifo2.sv
// Two-entry operand-pair queue, no bypass from push to head.
// Pointers wrap modulo 2; explicit occupancy count 0..2.
module op_fifo2
  import booth_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  op_pair_t wdata,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output op_pair_t head
);

  op_pair_t   mem_q [2];
  op_pair_t   mem_d [2];
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full    = (cnt_q == 2'(DEPTH));
  assign empty   = (cnt_q == 2'd0);
  assign head    = mem_q[rp_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // next storage, pointers and count
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = ~wp_q;
    end
    if (do_pop) begin
      rp_d = ~rp_q;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // queue state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for an external iterative Booth multiplier: queues pairs,
// loads the datapath, waits the step count and captures the product.
module booth_seq_ctrl #(
  parameter int N_BITS     = booth_seq_ctrl_pkg::N_BITS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  booth_seq_ctrl_if.slave bus
);
  import booth_seq_ctrl_pkg::*;

  localparam int PW = 2 * N_BITS;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [PW-1:0]     p_q, p_d;
  logic              ovf_q, ovf_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;

  logic     full, empty;
  logic     push, start;
  op_pair_t wr, head;

  assign wr    = '{a: bus.in_a, b: bus.in_b};
  assign push  = bus.in_valid & ~full;
  assign start = ~rst & (state_q == IDLE) & ~empty
               & (~ov_q | bus.out_ready);

  op_fifo2 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr),
    .pop   (start),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.in_ready  = ~full;
  assign bus.mul_load  = start;
  assign bus.mul_a     = start ? head.a : a_q;
  assign bus.mul_b     = start ? head.b : b_q;
  assign bus.out_valid = ov_q;
  assign bus.out_p     = p_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = ~rst & (state_q != IDLE);

  // FSM next state, step count, operand hold and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = head.a;
          b_d     = head.b;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(BOOTH_STEPS - 1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        p_d     = bus.mul_p;
        ov_d    = 1'b1;
        ovf_d   = (a_q == MIN_OPERAND)
                & (b_q == MIN_OPERAND);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ov_q    <= 1'b0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule
